// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory port between a word write path and a word read path.
// Define MEM_ARB_WR_PRIO_EN for fixed write priority; the default build arbitrates round-robin.
module mem_port_arbiter #(
    parameter int MEM_DEPTH = 2000001,
    parameter int ADDR_W    = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_strb,
    output logic              wr_done,
    output logic              wr_err,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_done,
    output logic [31:0]       rd_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [31:0]       mem_sel,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [7:0]        mem_rdata
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_LANE  = 3'd1;
    localparam logic [2:0] S_RD_ISSUE = 3'd2;
    localparam logic [2:0] S_RD_CAPT  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic GNT_READ  = 1'b0;
    localparam logic GNT_WRITE = 1'b1;

    // One extra bit so base+3 near the top of the address space cannot wrap past the check.
    localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_DEPTH - 1);

    logic [2:0]        state;
    logic [1:0]        lane;
    logic              last_grant;
    logic [ADDR_W-1:0] base;
    logic [31:0]       data_q;
    logic [3:0]        strb_q;
    logic              err_q;
    logic [23:0]       rd_buf;

    logic              any_req;
    logic              grant_wr;
    logic [ADDR_W-1:0] req_base;
    logic [ADDR_W:0]   req_end;
    logic              range_err;
    logic [3:0]        lane_onehot;
    logic [7:0]        lane_byte;

    assign any_req = wr_req | rd_req;

`ifdef MEM_ARB_WR_PRIO_EN
    assign grant_wr = wr_req;
`else
    assign grant_wr = wr_req && (!rd_req || last_grant == GNT_READ);
`endif

    assign req_base  = (grant_wr ? wr_addr : rd_addr) & ~ADDR_W'(3);
    assign req_end   = {1'b0, req_base} + (ADDR_W+1)'(3);
    assign range_err = req_end > LAST_BYTE;

    assign lane_onehot = 4'b0001 << lane;
    assign lane_byte   = data_q[{lane, 3'b000} +: 8];

    // NOTE: every register here is written with <= so all flops update together at the edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            lane       <= 2'd0;
            last_grant <= GNT_READ;
            base       <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            err_q      <= 1'b0;
            rd_buf     <= '0;
            rd_data    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        last_grant <= grant_wr;
                        base       <= req_base;
                        data_q     <= wr_data;
                        strb_q     <= wr_strb;
                        lane       <= 2'd0;
                        err_q      <= range_err;
                        if (range_err) begin
                            state <= S_DONE;
                            if (!grant_wr) rd_data <= '0;
                        end else begin
                            state <= grant_wr ? S_WR_LANE : S_RD_ISSUE;
                        end
                    end
                end
                S_WR_LANE: begin
                    lane <= lane + 2'd1;
                    if (lane == 2'd3) state <= S_DONE;
                end
                S_RD_ISSUE: state <= S_RD_CAPT;
                S_RD_CAPT: begin
                    lane <= lane + 2'd1;
                    case (lane)
                        2'd0: rd_buf[7:0]   <= mem_rdata;
                        2'd1: rd_buf[15:8]  <= mem_rdata;
                        2'd2: rd_buf[23:16] <= mem_rdata;
                        default: rd_data    <= {mem_rdata, rd_buf};
                    endcase
                    state <= (lane == 2'd3) ? S_DONE : S_RD_ISSUE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from state, so reset drops them without waiting for an edge.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        mem_addr  = '0;
        mem_wdata = '0;
        mem_sel   = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        case (state)
            S_WR_LANE: begin
                mem_addr  = base + ADDR_W'(lane);
                mem_wdata = lane_byte;
                mem_sel   = {28'b0, lane_onehot};
                mem_wen   = strb_q[lane];
            end
            S_RD_ISSUE: begin
                mem_addr = base + ADDR_W'(lane);
                mem_sel  = {28'b0, lane_onehot};
                mem_ren  = 1'b1;
            end
            default: ;
        endcase
    end

    assign wr_done = (state == S_DONE) && (last_grant == GNT_WRITE);
    assign rd_done = (state == S_DONE) && (last_grant == GNT_READ);
    assign wr_err  = wr_done && err_q;
    assign rd_err  = rd_done && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a
// transaction-level byte-memory model; honours MEM_ARB_WR_PRIO_EN for expected grant order.
module tb_mem_port_arbiter;

    localparam int MEM_DEPTH = 2000001;
    localparam int ADDR_W    = 32;
`ifdef MEM_ARB_WR_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_strb = '0;
    logic        wr_done, wr_err;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic        rd_done, rd_err;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [31:0] mem_sel;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_rdata = 8'h00;

    mem_port_arbiter #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_done(wr_done), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data), .rd_err(rd_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    // Byte memory seen by the DUT, and the expected contents derived from whole transactions.
    logic [7:0] sim_mem [int unsigned];
    logic [7:0] ref_mem [int unsigned];
    bit          model_last_wr = 1'b0;
    logic [31:0] last_rd = '0;

    int wen_cnt [4] = '{0, 0, 0, 0};
    int ren_cnt = 0;
    int wr_cyc_cnt = 0;
    int viol_cnt = 0;

    logic [31:0] edge_addr [6] = '{32'd1999996, 32'd1999998, 32'd2000000,
                                   32'd2000001, 32'hFFFF_FFFC, 32'hFFFF_FFFF};

    always @(posedge aclk) if (mem_wen) sim_mem[mem_addr] = mem_wdata;

    always @(negedge aclk) if (mem_ren) mem_rdata = sim_mem.exists(mem_addr) ? sim_mem[mem_addr] : 8'h00;

    always @(negedge aclk) begin
        if (mem_wen) for (int n = 0; n < 4; n++) if (mem_sel[n]) wen_cnt[n]++;
        if (mem_ren) ren_cnt++;
        if (mem_sel != 0 && !mem_ren) wr_cyc_cnt++;
        if ((mem_wen && mem_ren) || ((mem_wen || mem_ren) && !$onehot(mem_sel[3:0])) ||
            (mem_sel[31:4] != 0) || ((wr_done || rd_done) && (mem_wen || mem_ren || mem_sel != 0)) ||
            (wr_done && rd_done))
            viol_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr);
        logic [63:0] last_byte;
        last_byte = {32'b0, addr[31:2], 2'b00} + 64'd3;
        return last_byte > 64'(MEM_DEPTH - 1);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] w;
        int unsigned a;
        for (int n = 0; n < 4; n++) begin
            a = {addr[31:2], 2'b00} + n;
            w[8*n +: 8] = ref_mem.exists(a) ? ref_mem[a] : 8'h00;
        end
        return w;
    endfunction

    function automatic logic [31:0] sim_word(input logic [31:0] addr);
        logic [31:0] w;
        int unsigned a;
        for (int n = 0; n < 4; n++) begin
            a = {addr[31:2], 2'b00} + n;
            w[8*n +: 8] = sim_mem.exists(a) ? sim_mem[a] : 8'h00;
        end
        return w;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int unsigned a;
        for (int n = 0; n < 4; n++) begin
            a = {addr[31:2], 2'b00} + n;
            if (strb[n]) ref_mem[a] = data[8*n +: 8];
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {wr_done, wr_err, rd_done, rd_err, mem_wen, mem_ren, mem_wdata}, 64'h0);
        check({tag, "_sel"}, mem_sel, 64'h0);
        check({tag, "_addr"}, mem_addr, 64'h0);
        check({tag, "_rdata"}, rd_data, 64'h0);
    endtask

    // Called at the start of an idle cycle; cycle numbering counts the request cycle as 1.
    task automatic run_txn(input bit is_wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
        int cyc;
        bit seen;
        bit exp_err;
        int w0 [4];
        int r0, c0;
        logic [15:0] wen_obs, wen_exp;
        exp_err = model_err(addr);
        for (int n = 0; n < 4; n++) w0[n] = wen_cnt[n];
        r0 = ren_cnt;
        c0 = wr_cyc_cnt;
        if (is_wr) begin
            wr_addr = addr; wr_data = data; wr_strb = strb; wr_req = 1'b1;
        end else begin
            rd_addr = addr; rd_req = 1'b1;
        end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge aclk);
            cyc++;
            seen = is_wr ? wr_done : rd_done;
        end
        check(is_wr ? "wr_latency" : "rd_latency", cyc, exp_err ? 2 : (is_wr ? 6 : 10));
        if (is_wr) begin
            check("wr_err", wr_err, exp_err);
            if (!exp_err) model_write(addr, data, strb);
        end else begin
            check("rd_err", rd_err, exp_err);
            check("rd_data", rd_data, exp_err ? 32'h0 : ref_word(addr));
            last_rd = rd_data;
        end
        @(posedge aclk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        for (int n = 0; n < 4; n++) begin
            wen_obs[4*n +: 4] = 4'(wen_cnt[n] - w0[n]);
            wen_exp[4*n +: 4] = (is_wr && !exp_err && strb[n]) ? 4'd1 : 4'd0;
        end
        check("wen_lanes", wen_obs, wen_exp);
        check("wr_lane_cycles", wr_cyc_cnt - c0, (is_wr && !exp_err) ? 4 : 0);
        check("ren_cycles", ren_cnt - r0, (!is_wr && !exp_err) ? 4 : 0);
        if (is_wr && !exp_err) check("mem_image", sim_word(addr), ref_word(addr));
        model_last_wr = is_wr;
    endtask

    initial begin
        int cyc;
        bit seen;
        bit exp_wr;
        bit got_wr;
        bit r_wr;
        logic [31:0] r_addr, r_data;
        logic [3:0]  r_strb;

        repeat (3) @(negedge aclk);
        check_outputs_zero("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Full-word write then read back.
        run_txn(1'b1, 32'h100, 32'hA1B2C3D4, 4'hF);
        check("tp1_bytes", sim_word(32'h100), 32'hA1B2C3D4);
        run_txn(1'b0, 32'h100, 32'h0, 4'h0);
        check("tp1_read", last_rd, 32'hA1B2C3D4);

        // Partial strobes keep the untouched lanes.
        run_txn(1'b1, 32'h100, 32'h11223344, 4'b0101);
        run_txn(1'b0, 32'h100, 32'h0, 4'h0);
        check("tp2_read", last_rd, 32'hA122C344);

        // Range boundary: last legal word, first illegal word.
        run_txn(1'b0, 32'd2000000, 32'h0, 4'h0);
        check("oob_rd_data", last_rd, 32'h0);
        run_txn(1'b1, 32'd2000000, 32'h5A5A5A5A, 4'hF);
        run_txn(1'b1, 32'd1999996, 32'h76543210, 4'hF);
        run_txn(1'b0, 32'd1999996, 32'h0, 4'h0);
        check("top_word_read", last_rd, 32'h76543210);

        // Both sides request continuously for four transactions.
        wr_addr = 32'h400; wr_data = 32'hCAFEF00D; wr_strb = 4'hF; rd_addr = 32'h400;
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_wr = PRIO ? 1'b1 : !model_last_wr;
            cyc = 0;
            seen = 1'b0;
            while (!seen && cyc < 40) begin
                @(negedge aclk);
                cyc++;
                seen = wr_done | rd_done;
            end
            got_wr = wr_done;
            check($sformatf("arb_order_%0d", t), got_wr, exp_wr);
            check($sformatf("arb_latency_%0d", t), cyc, got_wr ? 6 : 10);
            if (got_wr) model_write(32'h400, 32'hCAFEF00D, 4'hF);
            else check($sformatf("arb_rd_data_%0d", t), rd_data, ref_word(32'h400));
            model_last_wr = got_wr;
        end
        @(posedge aclk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Write arriving while a read is capturing waits for the read to finish.
        rd_addr = 32'h100;
        rd_req = 1'b1;
        cyc = 0;
        repeat (3) begin @(negedge aclk); cyc++; end
        check("ovl_capt_ren", mem_ren, 1'b0);
        #1;
        wr_addr = 32'h104; wr_data = 32'h0BADCAFE; wr_strb = 4'hF; wr_req = 1'b1;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge aclk);
            cyc++;
            seen = rd_done;
        end
        check("ovl_rd_latency", cyc, 10);
        check("ovl_rd_data", rd_data, ref_word(32'h100));
        @(posedge aclk);
        #1;
        rd_req = 1'b0;
        @(negedge aclk);
        check("ovl_idle_sel", mem_sel, 64'h0);
        @(negedge aclk);
        check("ovl_wr_granted", {mem_wen, mem_sel[3:0]}, 5'b1_0001);
        cyc = 12;
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(negedge aclk);
            cyc++;
            seen = wr_done;
        end
        check("ovl_wr_done_cycle", cyc, 16);
        check("ovl_wr_err", wr_err, 1'b0);
        @(posedge aclk);
        #1;
        wr_req = 1'b0;
        model_write(32'h104, 32'h0BADCAFE, 4'hF);
        model_last_wr = 1'b1;
        check("ovl_mem_image", sim_word(32'h104), 32'h0BADCAFE);

        // Randomized mix of reads and writes, including range edges.
        for (int i = 0; i < 40; i++) begin
            r_wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) r_addr = edge_addr[$urandom_range(0, 5)];
            else r_addr = 32'h300 + $urandom_range(0, 63);
            r_data = $urandom;
            r_strb = 4'($urandom_range(0, 15));
            run_txn(r_wr, r_addr, r_data, r_strb);
        end

        // Reset during lane 2 of a write leaves lanes 0-1 written.
        run_txn(1'b1, 32'h200, 32'h55667788, 4'hF);
        wr_addr = 32'h200; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; wr_req = 1'b1;
        repeat (4) @(negedge aclk);
        check("rst_at_lane2", mem_sel, 64'h4);
        #1;
        aresetn = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        wr_req = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            if (wr_done) seen = 1'b1;
        end
        check("rst_no_done", seen, 1'b0);
        aresetn = 1'b1;
        ref_mem[32'h200] = 8'hEF;
        ref_mem[32'h201] = 8'hBE;
        model_last_wr = 1'b0;
        check("rst_partial_bytes", sim_word(32'h200), 32'h5566BEEF);
        @(posedge aclk);
        #1;
        run_txn(1'b0, 32'h200, 32'h0, 4'h0);
        check("rst_read_back", last_rd, 32'h5566BEEF);

        check("protocol_violations", viol_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
